// File: rtl/mem_wb_stage.sv
// mem_wb_stage: final (write-back) stage of the MIPS pipeline.
//
// Holds at most one instruction coming from MEM. A non-load retires in the
// cycle after it is captured. A load waits for dm_data_ok, and then its data
// is aligned and extended before it goes to the register-file write port.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   flush          squashes the stage content (exception / ERET)
//   m_*            instruction fields presented by MEM; m_allowin is the accept
//   dm_data_ok     load data valid this cycle
//   dm_rdata       load data word
//   wb_rf_*        register-file write port (address/data are 0 when we=0)
//   wb_retire      one-cycle pulse when the held instruction completes
//   wb_pc          PC of the held instruction (RESET_PC after reset)
//   wb_busy        a load is held and waiting for data
//
// Handshake: MEM transfers an instruction on a rising edge where m_valid and
// m_allowin are both 1. m_allowin never depends on m_valid. The stage accepts
// an instruction when it is empty or when its current instruction retires in
// the same cycle. Data memory offers no back-pressure, so dm_data_ok is a
// one-cycle strobe.
module mem_wb_stage #(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'hBFC0_0000)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            m_valid,
   output logic            m_allowin,
   input  logic [PC_W-1:0] m_pc,
   input  logic            m_regwrite,
   input  logic [4:0]      m_wreg,
   input  logic [31:0]     m_result,
   input  logic            m_is_load,
   input  logic [2:0]      m_ld_type,
   input  logic [1:0]      m_addr_lo,
   input  logic [31:0]     m_rt_val,
   input  logic            dm_data_ok,
   input  logic [31:0]     dm_rdata,
   output logic            wb_rf_we,
   output logic [4:0]      wb_rf_addr,
   output logic [31:0]     wb_rf_wdata,
   output logic            wb_retire,
   output logic [PC_W-1:0] wb_pc,
   output logic            wb_busy
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_RUN   = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        cancel, cancel_nxt;
   logic        regwrite_q;
   logic [4:0]  wreg_q;
   logic [31:0] result_q;
   logic [2:0]  ld_type_q;
   logic [1:0]  addr_lo_q;
   logic [31:0] rt_val_q;
   logic        retire;
   logic        capture;
   logic [31:0] load_data;

   // Little-endian alignment of the returned word. Codes 0 and 7 both act as LW.
   always_comb begin
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'h00;
      h = 16'h0000;
      load_data = dm_rdata;
      case (addr_lo_q)
         2'd0:    b = dm_rdata[7:0];
         2'd1:    b = dm_rdata[15:8];
         2'd2:    b = dm_rdata[23:16];
         default: b = dm_rdata[31:24];
      endcase
      h = addr_lo_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (ld_type_q)
         3'd1: load_data = {{24{b[7]}}, b};
         3'd2: load_data = {24'h0, b};
         3'd3: load_data = {{16{h[15]}}, h};
         3'd4: load_data = {16'h0, h};
         3'd5: begin
            case (addr_lo_q)
               2'd0:    load_data = {dm_rdata[7:0],  rt_val_q[23:0]};
               2'd1:    load_data = {dm_rdata[15:0], rt_val_q[15:0]};
               2'd2:    load_data = {dm_rdata[23:0], rt_val_q[7:0]};
               default: load_data = dm_rdata;
            endcase
         end
         3'd6: begin
            case (addr_lo_q)
               2'd0:    load_data = dm_rdata;
               2'd1:    load_data = {rt_val_q[31:24], dm_rdata[31:8]};
               2'd2:    load_data = {rt_val_q[31:16], dm_rdata[31:16]};
               default: load_data = {rt_val_q[31:8],  dm_rdata[31:24]};
            endcase
         end
         default: load_data = dm_rdata;
      endcase
   end

   // Next state and outputs. The data_ok that belongs to a squashed load
   // arrives after the flush. The cancel flag absorbs that data_ok so that it
   // cannot complete a newer load.
   always_comb begin
      state_nxt   = state;
      cancel_nxt  = cancel;
      retire      = 1'b0;
      m_allowin   = 1'b0;
      capture     = 1'b0;
      wb_rf_we    = 1'b0;
      wb_rf_addr  = 5'd0;
      wb_rf_wdata = 32'd0;
      wb_busy     = (state == S_WAIT);

      if (!flush) begin
         case (state)
            S_RUN:   retire = 1'b1;
            S_WAIT:  retire = dm_data_ok && !cancel;
            default: retire = 1'b0;
         endcase
         m_allowin = (state == S_EMPTY) || retire;
      end
      capture = m_valid && m_allowin;

      if (state == S_WAIT && dm_data_ok && cancel) cancel_nxt = 1'b0;
      if (flush && state == S_WAIT && !dm_data_ok) cancel_nxt = 1'b1;

      if (flush)        state_nxt = S_EMPTY;
      else if (capture) state_nxt = m_is_load ? S_WAIT : S_RUN;
      else if (retire)  state_nxt = S_EMPTY;

      if (retire && regwrite_q && wreg_q != 5'd0) begin
         wb_rf_we    = 1'b1;
         wb_rf_addr  = wreg_q;
         wb_rf_wdata = (state == S_WAIT) ? load_data : result_q;
      end
   end

   assign wb_retire = retire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_EMPTY;
         cancel <= 1'b0;
      end else begin
         state  <= state_nxt;
         cancel <= cancel_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_pc      <= RESET_PC;
         regwrite_q <= 1'b0;
         wreg_q     <= 5'd0;
         result_q   <= 32'd0;
         ld_type_q  <= 3'd0;
         addr_lo_q  <= 2'd0;
         rt_val_q   <= 32'd0;
      end else if (capture) begin
         wb_pc      <= m_pc;
         regwrite_q <= m_regwrite;
         wreg_q     <= m_wreg;
         result_q   <= m_result;
         ld_type_q  <= m_ld_type;
         addr_lo_q  <= m_addr_lo;
         rt_val_q   <= m_rt_val;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst, flush, m_valid, m_allowin;
   logic [31:0] m_pc;
   logic        m_regwrite;
   logic [4:0]  m_wreg;
   logic [31:0] m_result;
   logic        m_is_load;
   logic [2:0]  m_ld_type;
   logic [1:0]  m_addr_lo;
   logic [31:0] m_rt_val;
   logic        dm_data_ok;
   logic [31:0] dm_rdata;
   logic        wb_rf_we;
   logic [4:0]  wb_rf_addr;
   logic [31:0] wb_rf_wdata;
   logic        wb_retire;
   logic [31:0] wb_pc;
   logic        wb_busy;

   int checks = 0;
   int errors = 0;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .m_valid(m_valid), .m_allowin(m_allowin),
      .m_pc(m_pc), .m_regwrite(m_regwrite), .m_wreg(m_wreg), .m_result(m_result),
      .m_is_load(m_is_load), .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo),
      .m_rt_val(m_rt_val), .dm_data_ok(dm_data_ok), .dm_rdata(dm_rdata),
      .wb_rf_we(wb_rf_we), .wb_rf_addr(wb_rf_addr), .wb_rf_wdata(wb_rf_wdata),
      .wb_retire(wb_retire), .wb_pc(wb_pc), .wb_busy(wb_busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic        regwrite;
      logic [4:0]  wreg;
      logic [31:0] result;
      logic        is_load;
      logic [2:0]  ld_type;
      logic [1:0]  lo;
      logic [31:0] rt;
   } instr_t;

   instr_t      stage_q[$];
   logic        m_cancel;
   logic [31:0] m_last_pc;
   logic [31:0] exp_q[$];   // expected register-file write data, oldest first

   function automatic logic [31:0] model_align(instr_t h, logic [31:0] rd);
      int          l;
      logic [31:0] b, hw;
      l  = int'(h.lo);
      b  = (rd >> (8 * l)) & 32'hFF;
      hw = (rd >> (h.lo[1] ? 16 : 0)) & 32'hFFFF;
      case (h.ld_type)
         3'd1: return b[7]   ? (b  | 32'hFFFF_FF00) : b;
         3'd2: return b;
         3'd3: return hw[15] ? (hw | 32'hFFFF_0000) : hw;
         3'd4: return hw;
         3'd5: return (rd << (8 * (3 - l))) | (h.rt & ((32'h1 << (8 * (3 - l))) - 32'h1));
         3'd6: return (rd >> (8 * l)) | (h.rt & ~(32'hFFFF_FFFF >> (8 * l)));
         default: return rd;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Compares every output against the model, then advances the model by one edge.
   task automatic model_cycle();
      logic        held, ret, allow, we;
      logic [31:0] wd;
      instr_t      h, n;
      held = (stage_q.size() != 0);
      if (held) h = stage_q[0];
      ret   = !flush && held && (!h.is_load || (dm_data_ok && !m_cancel));
      allow = !flush && (!held || ret);
      we    = ret && h.regwrite && (h.wreg != 5'd0);
      wd    = 32'd0;
      if (we) begin
         wd = h.is_load ? model_align(h, dm_rdata) : h.result;
         exp_q.push_back(wd);
      end
      chk("m_allowin", {31'd0, m_allowin}, {31'd0, allow});
      chk("wb_retire", {31'd0, wb_retire}, {31'd0, ret});
      chk("wb_rf_we", {31'd0, wb_rf_we}, {31'd0, we});
      chk("wb_rf_addr", {27'd0, wb_rf_addr}, we ? {27'd0, h.wreg} : 32'd0);
      chk("wb_busy", {31'd0, wb_busy}, {31'd0, held && h.is_load});
      chk("wb_pc", wb_pc, m_last_pc);
      if (wb_rf_we && exp_q.size() != 0) chk("wb_rf_wdata", wb_rf_wdata, exp_q.pop_front());
      else chk("wb_rf_wdata_idle", wb_rf_wdata, wd);
      exp_q.delete();

      if (rst) begin
         stage_q.delete();
         m_cancel  = 1'b0;
         m_last_pc = 32'hBFC0_0000;
      end else begin
         if (held && h.is_load) begin
            if (flush && !dm_data_ok) m_cancel = 1'b1;
            else if (dm_data_ok && m_cancel) m_cancel = 1'b0;
         end
         if (ret || flush) void'(stage_q.pop_front());
         if (m_valid && allow) begin
            n = '{m_regwrite, m_wreg, m_result, m_is_load, m_ld_type, m_addr_lo, m_rt_val};
            stage_q.push_back(n);
            m_last_pc = m_pc;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; flush = 0; m_valid = 0; m_pc = 0; m_regwrite = 0; m_wreg = 0;
      m_result = 0; m_is_load = 0; m_ld_type = 0; m_addr_lo = 0; m_rt_val = 0;
      dm_data_ok = 0; dm_rdata = 0;
   endtask

   task automatic present(input logic ld, input logic [2:0] ty, input logic [1:0] lo,
                          input logic [4:0] wr, input logic [31:0] res, input logic [31:0] rt);
      m_valid = 1; m_is_load = ld; m_ld_type = ty; m_addr_lo = lo; m_regwrite = 1;
      m_wreg = wr; m_result = res; m_rt_val = rt; m_pc = m_pc + 32'd4;
   endtask

   // Load with data_ok arriving 3 cycles after capture: two empty WAIT cycles, then data.
   task automatic load_test(input string name, input logic [2:0] ty, input logic [1:0] lo,
                            input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
      present(1, ty, lo, 5'd5, 32'h0, rt);
      tick();
      m_valid = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk({name, "_busy"}, {31'd0, wb_busy}, 32'd1);
         chk({name, "_allowin"}, {31'd0, m_allowin}, 32'd0);
         tick();
      end
      dm_data_ok = 1; dm_rdata = rd;
      #1;
      chk({name, "_we"}, {31'd0, wb_rf_we}, 32'd1);
      chk({name, "_wdata"}, wb_rf_wdata, exp);
      tick();
      dm_data_ok = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle();
      rst = 1;
      stage_q.delete();
      m_cancel = 0;
      m_last_pc = 32'hBFC0_0000;
      repeat (2) @(posedge clk);
      #1;
      tick();
      rst = 0;
      #1;
      chk("reset_allowin", {31'd0, m_allowin}, 32'd1);
      chk("reset_pc", wb_pc, 32'hBFC0_0000);
      chk("reset_retire", {31'd0, wb_retire}, 32'd0);

      // back-to-back ALU ops
      present(0, 0, 0, 5'd3, 32'h11, 0); tick();
      present(0, 0, 0, 5'd4, 32'h22, 0); #1;
      chk("alu_r3_addr", {27'd0, wb_rf_addr}, 32'd3);
      chk("alu_r3_data", wb_rf_wdata, 32'h11);
      chk("alu_allowin", {31'd0, m_allowin}, 32'd1);
      tick();
      present(0, 0, 0, 5'd0, 32'h33, 0); #1;
      chk("alu_r4_data", wb_rf_wdata, 32'h22);
      tick();
      m_valid = 0; #1;
      chk("alu_r0_retire", {31'd0, wb_retire}, 32'd1);
      chk("alu_r0_we", {31'd0, wb_rf_we}, 32'd0);
      tick();

      load_test("lb1",  3'd1, 2'd1, 32'h0, 32'h1280_3456, 32'h0000_0034);
      load_test("lb2",  3'd1, 2'd2, 32'h0, 32'h1280_3456, 32'hFFFF_FF80);
      load_test("lbu2", 3'd2, 2'd2, 32'h0, 32'h1280_3456, 32'h0000_0080);
      load_test("lwl1", 3'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);
      load_test("lwr2", 3'd6, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122);
      load_test("lh2",  3'd3, 2'd2, 32'h0, 32'h8001_0000, 32'hFFFF_8001);
      load_test("lhu2", 3'd4, 2'd2, 32'h0, 32'h8001_0000, 32'h0000_8001);

      // flush in WAIT, new LW, then stale and real data
      present(1, 0, 0, 5'd7, 0, 0); tick();
      m_valid = 0; flush = 1; #1;
      chk("flush_allowin", {31'd0, m_allowin}, 32'd0);
      chk("flush_retire", {31'd0, wb_retire}, 32'd0);
      tick();
      flush = 0;
      present(1, 0, 0, 5'd6, 0, 0); tick();
      m_valid = 0; dm_data_ok = 1; dm_rdata = 32'hDEAD; #1;
      chk("stale_retire", {31'd0, wb_retire}, 32'd0);
      chk("stale_we", {31'd0, wb_rf_we}, 32'd0);
      tick();
      dm_rdata = 32'hBEEF; #1;
      chk("beef_addr", {27'd0, wb_rf_addr}, 32'd6);
      chk("beef_data", wb_rf_wdata, 32'hBEEF);
      tick();
      dm_data_ok = 0;

      // reset mid-WAIT
      present(1, 0, 0, 5'd8, 0, 0); tick();
      m_valid = 0; tick();
      rst = 1; tick();
      rst = 0; #1;
      chk("rst_allowin", {31'd0, m_allowin}, 32'd1);
      chk("rst_pc", wb_pc, 32'hBFC0_0000);
      chk("rst_busy", {31'd0, wb_busy}, 32'd0);
      dm_data_ok = 1; dm_rdata = 32'h1234; #1;
      chk("rst_stale_we", {31'd0, wb_rf_we}, 32'd0);
      tick();
      idle();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic in_wait;
         in_wait = (stage_q.size() != 0) && stage_q[0].is_load;
         rst   = ($urandom_range(0, 63) == 0);
         flush = ($urandom_range(0, 15) == 0);
         m_valid = ($urandom_range(0, 2) != 0);
         m_pc = $urandom; m_regwrite = ($urandom_range(0, 3) != 0);
         m_wreg = 5'($urandom_range(0, 31)); m_result = $urandom;
         m_is_load = $urandom_range(0, 1); m_ld_type = 3'($urandom_range(0, 7));
         m_addr_lo = 2'($urandom_range(0, 3)); m_rt_val = $urandom;
         dm_rdata = $urandom;
         dm_data_ok = ($urandom_range(0, 2) == 0);
         // keep data_ok away from the cases where a stale strobe outside WAIT is ambiguous
         if (!in_wait && m_cancel) dm_data_ok = 0;
         if (m_cancel && flush) dm_data_ok = 0;
         tick();
      end
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
